// File: rtl/bmc_pkg.sv
// bmc_pkg: shared slot map, FSM state type and the decoded-subframe record
// used by the biphase-mark frame sequencer and its subframe collector.
package bmc_pkg;

    // Slot positions inside the 28-slot subframe payload (arrival order).
    localparam int SLOT_V         = 24;
    localparam int SLOT_U         = 25;
    localparam int SLOT_C         = 26;
    localparam int SLOT_P         = 27;
    localparam int SUBFRAME_SLOTS = 28;

    // Sample field occupies slots 0..SLOT_V-1.
    localparam int SAMPLE_BITS    = SLOT_V;

    typedef enum logic {
        WAIT_A = 1'b0,
        WAIT_B = 1'b1
    } state_t;

    typedef struct packed {
        logic [SAMPLE_BITS-1:0] sample;
        logic                   v;
        logic                   u;
        logic                   c;
        logic [7:0]             frame;
        logic                   channel;
    } subframe_t;

endpackage

// File: rtl/bmc_subframe_collector.sv
// bmc_subframe_collector: assembles one 28-slot subframe from the decoded
// bit stream, tracking slot position, subframe tag, idle timeout and parity.
//
// Ports:
//   clk, rst          system clock, async active-high reset
//   bit_valid         one decoded bit this cycle
//   bit_data          decoded bit value
//   bit_channel       0 = A, 1 = B
//   bit_frame         frame number 0..191
//   sf                assembled subframe (valid while sf_done is high)
//   sf_done           slot 27 accepted and parity good (combinational)
//   sf_err_short      subframe cut short by a tag change or idle timeout
//   sf_err_parity     slot 27 accepted with bad parity
module bmc_subframe_collector
    import bmc_pkg::*;
#(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_valid,
    input  logic       bit_data,
    input  logic       bit_channel,
    input  logic [7:0] bit_frame,
    output subframe_t  sf,
    output logic       sf_done,
    output logic       sf_err_short,
    output logic       sf_err_parity
);

    localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] IDLE_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [4:0]    LAST_SLOT = 5'(SLOT_P);

    logic [4:0]      cnt_q, cnt_d;
    logic [8:0]      tag_q, tag_d;
    logic [SLOT_C:0] shreg_q, shreg_d;
    logic            par_q, par_d;
    logic [TW-1:0]   idle_q, idle_d;

    logic [8:0]      tag_in;
    logic            busy;
    logic            tag_hit;

    assign tag_in  = {bit_frame, bit_channel};
    assign busy    = (cnt_q != 5'd0);
    assign tag_hit = (tag_in == tag_q);

    // Slots 0..26 are shifted in LSB-last, so after 27 shifts slot 0 sits at bit 0.
    always_comb begin
        sf.sample  = shreg_q[SLOT_V-1:0];
        sf.v       = shreg_q[SLOT_V];
        sf.u       = shreg_q[SLOT_U];
        sf.c       = shreg_q[SLOT_C];
        sf.frame   = tag_q[8:1];
        sf.channel = tag_q[0];
    end

    always_comb begin
        cnt_d         = cnt_q;
        tag_d         = tag_q;
        shreg_d       = shreg_q;
        par_d         = par_q;
        idle_d        = idle_q;
        sf_done       = 1'b0;
        sf_err_short  = 1'b0;
        sf_err_parity = 1'b0;

        if (bit_valid) begin
            idle_d = IDLE_LOAD;
            if (!busy || !tag_hit) begin
                // A tag change mid-subframe abandons the partial data; this
                // bit starts the next subframe.
                sf_err_short = busy;
                cnt_d        = 5'd1;
                tag_d        = tag_in;
                shreg_d      = {bit_data, shreg_q[SLOT_C:1]};
                par_d        = bit_data;
            end else if (cnt_q == LAST_SLOT) begin
                cnt_d         = 5'd0;
                sf_err_parity = par_q ^ bit_data;
                sf_done       = ~(par_q ^ bit_data);
            end else begin
                cnt_d   = cnt_q + 5'd1;
                shreg_d = {bit_data, shreg_q[SLOT_C:1]};
                par_d   = par_q ^ bit_data;
            end
        end else if (busy) begin
            if (idle_q == '0) begin
                sf_err_short = 1'b1;
                cnt_d        = 5'd0;
            end else begin
                idle_d = idle_q - TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            tag_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            idle_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            idle_q  <= idle_d;
        end
    end

endmodule

// File: rtl/bmc_frame_sequencer.sv
// bmc_frame_sequencer: pairs channel A/B subframes of the same frame into
// stereo samples, presents them through a one-deep valid/ready buffer,
// gathers channel-status bits and raises link error pulses.
//
// Ports:
//   clk, rst                 system clock, async active-high reset
//   bit_valid/data/channel   decoded bit stream from biphasemark_decode
//   bit_frame                decoder frame counter 0..191
//   pair_valid, pair_ready   output handshake
//   sample_l, sample_r       channel A / channel B samples
//   pair_frame, pair_vflag   frame number and OR of both V bits
//   cs_word, cs_valid        channel-status word and its update pulse
//   err_parity/seq/short/overflow  one-cycle error pulses
//
// Pairing FSM:
//   state  | meaning
//   WAIT_A | no A held; expecting a channel A subframe
//   WAIT_B | A held; expecting channel B of the same frame
module bmc_frame_sequencer
    import bmc_pkg::*;
#(
    parameter int SAMPLE_W    = 24,
    parameter int CS_BITS     = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bit_valid,
    input  logic                bit_data,
    input  logic                bit_channel,
    input  logic [7:0]          bit_frame,
    output logic                pair_valid,
    input  logic                pair_ready,
    output logic [SAMPLE_W-1:0] sample_l,
    output logic [SAMPLE_W-1:0] sample_r,
    output logic [7:0]          pair_frame,
    output logic                pair_vflag,
    output logic [CS_BITS-1:0]  cs_word,
    output logic                cs_valid,
    output logic                err_parity,
    output logic                err_seq,
    output logic                err_short,
    output logic                err_overflow
);

    localparam int IW = (CS_BITS > 1) ? $clog2(CS_BITS) : 1;

    subframe_t sf;
    logic      col_done;
    logic      col_err_short;
    logic      col_err_parity;

    bmc_subframe_collector #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_collector (
        .clk           (clk),
        .rst           (rst),
        .bit_valid     (bit_valid),
        .bit_data      (bit_data),
        .bit_channel   (bit_channel),
        .bit_frame     (bit_frame),
        .sf            (sf),
        .sf_done       (col_done),
        .sf_err_short  (col_err_short),
        .sf_err_parity (col_err_parity)
    );

    state_t                 state_q, state_d;
    logic [SAMPLE_BITS-1:0] a_sample_q, a_sample_d;
    logic                   a_v_q, a_v_d;
    logic [7:0]             a_frame_q, a_frame_d;

    logic [SAMPLE_W-1:0]    sample_l_q, sample_l_d;
    logic [SAMPLE_W-1:0]    sample_r_q, sample_r_d;
    logic [7:0]             pair_frame_q, pair_frame_d;
    logic                   pair_vflag_q, pair_vflag_d;
    logic                   pair_valid_q, pair_valid_d;

    logic [CS_BITS-1:0]     shadow_q, shadow_d;
    logic [CS_BITS-1:0]     mask_q, mask_d;
    logic [CS_BITS-1:0]     cs_word_q, cs_word_d;
    logic                   cs_valid_q, cs_valid_d;

    logic                   err_parity_q, err_parity_d;
    logic                   err_seq_q, err_seq_d;
    logic                   err_short_q, err_short_d;
    logic                   err_overflow_q, err_overflow_d;

    logic                   new_pair;
    logic [IW-1:0]          cs_idx;

    assign cs_idx = sf.frame[IW-1:0];

    always_comb begin
        state_d        = state_q;
        a_sample_d     = a_sample_q;
        a_v_d          = a_v_q;
        a_frame_d      = a_frame_q;
        sample_l_d     = sample_l_q;
        sample_r_d     = sample_r_q;
        pair_frame_d   = pair_frame_q;
        pair_vflag_d   = pair_vflag_q;
        pair_valid_d   = pair_valid_q;
        shadow_d       = shadow_q;
        mask_d         = mask_q;
        cs_word_d      = cs_word_q;
        cs_valid_d     = 1'b0;
        err_parity_d   = col_err_parity;
        err_short_d    = col_err_short;
        err_seq_d      = 1'b0;
        err_overflow_d = 1'b0;
        new_pair       = 1'b0;

        // Pairing FSM. A parity failure also drops any held A.
        if (col_err_parity) begin
            state_d = WAIT_A;
        end else if (col_done) begin
            case (state_q)
                WAIT_A: begin
                    if (!sf.channel) begin
                        a_sample_d = sf.sample;
                        a_v_d      = sf.v;
                        a_frame_d  = sf.frame;
                        state_d    = WAIT_B;
                    end else begin
                        err_seq_d = 1'b1;
                    end
                end
                WAIT_B: begin
                    if (!sf.channel) begin
                        // Newest A replaces the one still waiting for its B.
                        err_seq_d  = 1'b1;
                        a_sample_d = sf.sample;
                        a_v_d      = sf.v;
                        a_frame_d  = sf.frame;
                    end else begin
                        state_d = WAIT_A;
                        if (sf.frame == a_frame_q) begin
                            new_pair = 1'b1;
                        end else begin
                            err_seq_d = 1'b1;
                        end
                    end
                end
                default: state_d = WAIT_A;
            endcase
        end

        // One-deep output buffer; a pair arriving while the old one is
        // still unaccepted overwrites it.
        if (new_pair) begin
            sample_l_d     = SAMPLE_W'(a_sample_q);
            sample_r_d     = SAMPLE_W'(sf.sample);
            pair_frame_d   = sf.frame;
            pair_vflag_d   = a_v_q | sf.v;
            pair_valid_d   = 1'b1;
            err_overflow_d = pair_valid_q & ~pair_ready;
        end else if (pair_valid_q && pair_ready) begin
            pair_valid_d = 1'b0;
        end

        // Channel status from good A subframes in frames 0..CS_BITS-1.
        if (col_done && !sf.channel && (32'(sf.frame) < CS_BITS)) begin
            if (sf.frame == 8'd0) begin
                mask_d = '0;
            end
            mask_d[cs_idx]   = 1'b1;
            shadow_d[cs_idx] = sf.c;
            if ((32'(sf.frame) == CS_BITS - 1) && (&mask_d)) begin
                cs_word_d  = shadow_d;
                cs_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= WAIT_A;
            a_sample_q     <= '0;
            a_v_q          <= 1'b0;
            a_frame_q      <= '0;
            sample_l_q     <= '0;
            sample_r_q     <= '0;
            pair_frame_q   <= '0;
            pair_vflag_q   <= 1'b0;
            pair_valid_q   <= 1'b0;
            shadow_q       <= '0;
            mask_q         <= '0;
            cs_word_q      <= '0;
            cs_valid_q     <= 1'b0;
            err_parity_q   <= 1'b0;
            err_seq_q      <= 1'b0;
            err_short_q    <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_sample_q     <= a_sample_d;
            a_v_q          <= a_v_d;
            a_frame_q      <= a_frame_d;
            sample_l_q     <= sample_l_d;
            sample_r_q     <= sample_r_d;
            pair_frame_q   <= pair_frame_d;
            pair_vflag_q   <= pair_vflag_d;
            pair_valid_q   <= pair_valid_d;
            shadow_q       <= shadow_d;
            mask_q         <= mask_d;
            cs_word_q      <= cs_word_d;
            cs_valid_q     <= cs_valid_d;
            err_parity_q   <= err_parity_d;
            err_seq_q      <= err_seq_d;
            err_short_q    <= err_short_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign pair_valid   = pair_valid_q;
    assign sample_l     = sample_l_q;
    assign sample_r     = sample_r_q;
    assign pair_frame   = pair_frame_q;
    assign pair_vflag   = pair_vflag_q;
    assign cs_word      = cs_word_q;
    assign cs_valid     = cs_valid_q;
    assign err_parity   = err_parity_q;
    assign err_seq      = err_seq_q;
    assign err_short    = err_short_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_bmc_frame_sequencer.sv
// tb_bmc_frame_sequencer: scoreboard bench for bmc_frame_sequencer.
module tb_bmc_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_valid;
    logic        bit_data;
    logic        bit_channel;
    logic [7:0]  bit_frame;
    logic        pair_valid;
    logic        pair_ready;
    logic [23:0] sample_l;
    logic [23:0] sample_r;
    logic [7:0]  pair_frame;
    logic        pair_vflag;
    logic [31:0] cs_word;
    logic        cs_valid;
    logic        err_parity;
    logic        err_seq;
    logic        err_short;
    logic        err_overflow;

    bmc_frame_sequencer #(
        .SAMPLE_W    (24),
        .CS_BITS     (32),
        .TIMEOUT_CYC (256)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bit_valid    (bit_valid),
        .bit_data     (bit_data),
        .bit_channel  (bit_channel),
        .bit_frame    (bit_frame),
        .pair_valid   (pair_valid),
        .pair_ready   (pair_ready),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .pair_frame   (pair_frame),
        .pair_vflag   (pair_vflag),
        .cs_word      (cs_word),
        .cs_valid     (cs_valid),
        .err_parity   (err_parity),
        .err_seq      (err_seq),
        .err_short    (err_short),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [7:0]  f;
        logic        v;
    } pair_exp_t;

    pair_exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    int c_par = 0, c_seq = 0, c_short = 0, c_ovf = 0, c_csv = 0;
    int e_par = 0, e_seq = 0, e_short = 0, e_ovf = 0, e_csv = 0;

    localparam logic [31:0] CS_PAT = 32'hDEADBEEF;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_errs(input string tag);
        check({tag, "_par"},   c_par,   e_par);
        check({tag, "_seq"},   c_seq,   e_seq);
        check({tag, "_short"}, c_short, e_short);
        check({tag, "_ovf"},   c_ovf,   e_ovf);
    endtask

    // Drives nbits slots of one subframe on consecutive cycles.
    task automatic send_sub(input logic ch, input logic [7:0] fr, input logic [23:0] smp,
                            input logic v, input logic c, input logic flip_p, input int nbits);
        logic [27:0] s;
        s        = {1'b0, c, ^smp, v, smp};
        s[27]    = (^s[26:0]) ^ flip_p;
        for (int i = 0; i < nbits; i++) begin
            bit_valid   = 1'b1;
            bit_data    = s[i];
            bit_channel = ch;
            bit_frame   = fr;
            tick();
        end
        bit_valid = 1'b0;
        bit_data  = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] fr, input logic [23:0] l, input logic [23:0] r,
                             input logic va, input logic vb, input logic ca);
        pair_exp_t e;
        send_sub(1'b0, fr, l, va, ca, 1'b0, 28);
        send_sub(1'b1, fr, r, vb, 1'b0, 1'b0, 28);
        check("pv_latency", pair_valid, 1'b1);
        e = '{l: l, r: r, f: fr, v: va | vb};
        if (!pair_ready && sb.size() != 0) begin
            void'(sb.pop_back());
            e_ovf++;
        end
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (err_parity)   c_par++;
            if (err_seq)      c_seq++;
            if (err_short)    c_short++;
            if (err_overflow) c_ovf++;
            if (cs_valid)     c_csv++;
            if (pair_valid && pair_ready) begin
                pair_exp_t e;
                check("pair_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("sample_l",   sample_l,   e.l);
                    check("sample_r",   sample_r,   e.r);
                    check("pair_frame", pair_frame, e.f);
                    check("pair_vflag", pair_vflag, e.v);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bit_valid   = 1'b0;
        bit_data    = 1'b0;
        bit_channel = 1'b0;
        bit_frame   = 8'd0;
        pair_ready  = 1'b1;
        repeat (3) tick();
        check("rst_pair_valid", pair_valid, 0);
        check("rst_sample_l",   sample_l,   0);
        check("rst_sample_r",   sample_r,   0);
        check("rst_pair_frame", pair_frame, 0);
        check("rst_cs_word",    cs_word,    0);
        check("rst_errs", {cs_valid, err_parity, err_seq, err_short, err_overflow, pair_vflag}, 0);
        rst = 1'b0;
        tick();

        // Basic pair, frame 5.
        send_sub(1'b0, 8'd5, 24'h123456, 1'b0, 1'b0, 1'b0, 28);
        check("pv_after_a", pair_valid, 0);
        send_sub(1'b1, 8'd5, 24'hABCDEF, 1'b0, 1'b0, 1'b0, 28);
        check("pv_latency", pair_valid, 1'b1);
        sb.push_back('{l: 24'h123456, r: 24'hABCDEF, f: 8'd5, v: 1'b0});
        repeat (3) tick();
        check("pv_drop_basic", pair_valid, 0);
        check_errs("basic");

        // Bad parity on A, then orphan B.
        send_sub(1'b0, 8'd5, 24'h123456, 1'b0, 1'b0, 1'b1, 28);
        send_sub(1'b1, 8'd5, 24'hABCDEF, 1'b0, 1'b0, 1'b0, 28);
        e_par++;
        e_seq++;
        repeat (3) tick();
        check("pv_parity", pair_valid, 0);
        check_errs("parity");

        // Frame mismatch, then a good pair with V set on B.
        send_sub(1'b0, 8'd7, 24'h111111, 1'b0, 1'b0, 1'b0, 28);
        send_sub(1'b1, 8'd8, 24'h222222, 1'b0, 1'b0, 1'b0, 28);
        e_seq++;
        tick();
        check("pv_seq", pair_valid, 0);
        send_pair(8'd7, 24'h00F00F, 24'h5A5A5A, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        check_errs("seq");

        // Reset mid-subframe discards the partial data silently.
        send_sub(1'b0, 8'd3, 24'hFFFFFF, 1'b1, 1'b1, 1'b0, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        send_pair(8'd3, 24'h0A0B0C, 24'hC0B0A0, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        check_errs("midrst");

        // Tag change mid-subframe: new bit starts the next subframe.
        send_sub(1'b0, 8'd22, 24'h777777, 1'b0, 1'b0, 1'b0, 5);
        e_short++;
        send_pair(8'd23, 24'h345678, 24'h876543, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        check_errs("shorttag");

        // Idle timeout after 10 bits.
        send_sub(1'b0, 8'd20, 24'h999999, 1'b0, 1'b0, 1'b0, 10);
        repeat (255) tick();
        check("short_early", c_short, e_short);
        repeat (5) tick();
        e_short++;
        check("short_timeout", c_short, e_short);
        send_pair(8'd21, 24'h13579B, 24'h2468AC, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        check_errs("timeout");

        // Overflow: two pairs without ready, newest wins.
        pair_ready = 1'b0;
        send_pair(8'd10, 24'h0000AA, 24'h0000BB, 1'b0, 1'b0, 1'b0);
        send_pair(8'd11, 24'h0000CC, 24'h0000DD, 1'b1, 1'b0, 1'b0);
        tick();
        check("ovf_sample_l", sample_l, 24'h0000CC);
        check_errs("ovf");
        pair_ready = 1'b1;
        tick();
        check("pv_drop_ovf", pair_valid, 0);

        // Channel status: full sweep of frames 0..31.
        for (int f = 0; f < 32; f++) begin
            send_pair(8'(f), 24'(f * 3 + 1), 24'(f * 5 + 2), 1'b0, 1'b0, CS_PAT[f]);
        end
        e_csv++;
        repeat (3) tick();
        check("cs_valid_cnt", c_csv, e_csv);
        check("cs_word", cs_word, CS_PAT);

        // Frame 17 missing: no status update.
        for (int f = 0; f < 32; f++) begin
            if (f != 17) begin
                send_pair(8'(f), 24'(f + 100), 24'(f + 200), 1'b0, 1'b0, ~CS_PAT[f]);
            end
        end
        repeat (3) tick();
        check("cs_valid_gap", c_csv, e_csv);
        check("cs_word_hold", cs_word, CS_PAT);

        repeat (3) tick();
        check("sb_empty", sb.size(), 0);
        check_errs("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bmc_frame_sequencer.md
Name: bmc_frame_sequencer

Overview:
Sequences the decoded bit stream from biphasemark_decode into stereo sample pairs. It counts bit slots per subframe, checks parity, and pairs channel A with channel B of the same frame. It also gathers channel-status bits into a status word. Completed pairs go out through a one-deep valid/ready buffer to the audio sink, with error pulses for link monitoring.

Parameters:
SAMPLE_W, 24, sample width; aux + audio slots, LSB first
CS_BITS, 32, channel-status bits collected from channel A, frames 0..CS_BITS-1
TIMEOUT_CYC, 256, idle clocks mid-subframe before the subframe is aborted

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
bit_valid  in  1  decoder vout; one decoded data bit this cycle
bit_data  in  1  decoder dout
bit_channel  in  1  decoder channel; 0=A/left, 1=B/right
bit_frame  in  8  decoder frame_counter, 0..191
pair_valid  out  1  sample pair available
pair_ready  in  1  sink accepts pair
sample_l  out  SAMPLE_W  channel A sample
sample_r  out  SAMPLE_W  channel B sample
pair_frame  out  8  frame number of pair
pair_vflag  out  1  OR of V bits of both subframes
cs_word  out  CS_BITS  channel-status word, bit i = C of frame i
cs_valid  out  1  one-cycle pulse, cs_word updated
err_parity  out  1  one-cycle pulse
err_seq  out  1  one-cycle pulse
err_short  out  1  one-cycle pulse
err_overflow  out  1  one-cycle pulse

Behaviour:
- Reset: every output is 0, state WAIT_A, slot count 0, cs mask cleared. Reset mid-subframe discards all partial data.
- Subframe payload is 28 slots, in arrival order:
  - slots 0-23: sample, with sample[i] = slot i
  - slot 24: V
  - slot 25: U
  - slot 26: C
  - slot 27: P
- Slot counter advances only on bit_valid. The tag {bit_frame, bit_channel} is latched on slot 0.
- Short subframe: bit_valid arrives with a tag different from the latched tag while count is 1..27.
  - err_short pulses.
  - The partial subframe is discarded.
  - The current bit becomes slot 0 of the new subframe.
- Timeout: count is 1..27 and TIMEOUT_CYC consecutive clocks pass without bit_valid.
  - err_short pulses.
  - Count returns to 0.
- Completion happens on acceptance of slot 27. Parity = XOR of all 28 slots and must be 0.
  - Parity fail: err_parity pulses, the subframe is dropped, any held A is dropped, state goes to WAIT_A.
- State machine (WAIT_A, WAIT_B):
  - WAIT_A, A completes: store it, latch its frame number, go to WAIT_B.
  - WAIT_A, B completes: err_seq pulses, B is discarded, stay in WAIT_A.
  - WAIT_B, B completes with the latched frame number: form the pair, go to WAIT_A.
  - WAIT_B, B completes with a different frame number: err_seq pulses, go to WAIT_A.
  - WAIT_B, A completes: err_seq pulses, the new A replaces the old A, stay in WAIT_B.
- Output buffer:
  - Latency: pair_valid rises on the clock after B's slot 27 is accepted.
  - Transfer occurs when pair_valid && pair_ready. pair_valid then drops next cycle unless a new pair loads in the same cycle.
  - A new pair while pair_valid && !pair_ready: err_overflow pulses and the new pair overwrites the old one (newest wins).
  - A new pair in the same cycle as a transfer: no overflow; the new pair loads.
- Channel status (channel A subframes that pass parity, with frame < CS_BITS):
  - Store C into shadow[frame] and set mask[frame].
  - Frame 0 clears the mask before setting bit 0.
  - On completion of frame CS_BITS-1 with the full mask set: cs_word <= shadow and cs_valid pulses for 1 cycle.
  - Frames >= CS_BITS are ignored for status.
- Simultaneous error pulses are allowed. Each pulse lasts exactly one cycle per event.

Decomposition:
- Package bmc_pkg holds:
  - slot constants: SLOT_V=24, SLOT_U=25, SLOT_C=26, SLOT_P=27, SUBFRAME_SLOTS=28
  - typedef state_t {WAIT_A, WAIT_B}
  - struct subframe_t {sample, v, u, c, frame, channel}
- One sub-module, bmc_subframe_collector, owns the shift register, slot counter, tag compare, timeout, and parity. It emits a subframe_t plus done/err_short/err_parity pulses.
- The top module holds the pairing FSM, output buffer, and channel-status logic.

Test Plan:
- Frame 5: A=0x123456, B=0xABCDEF, both with correct parity, pair_ready=1 -> pair_valid one cycle after B slot 27; sample_l=0x123456, sample_r=0xABCDEF, pair_frame=5, no errors.
- Same as above but A's P bit flipped -> err_parity one pulse; B then gives err_seq; no pair_valid.
- A frame 7, then B for frame 8 -> err_seq pulse, no pair; next A7/B7 sequence -> pair with frame 7.
- Two full pairs with pair_ready=0 -> err_overflow pulse; sample_l holds the second pair's value; asserting pair_ready clears pair_valid the next cycle.
- A subframe stopped after 10 bits, idle 256 clocks -> err_short pulse; the following full pair is delivered correctly.
- Frames 0..31 with channel A C bits = 0xDEADBEEF pattern (bit i on frame i) -> cs_valid pulse after frame 31 A; cs_word=0xDEADBEEF. Repeating with frame 17 skipped -> no cs_valid.
